// File: rtl/alu_result_reader.sv
// Captures the ALU result pair on alu_done and streams it out byte by byte,
// low byte of result_lo first, over a valid/ready handshake.
module alu_result_reader #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] result_lo,
  input  logic [WIDTH-1:0] result_hi,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             sent,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int NBYTES = 2 * WIDTH / 8;
  localparam int CNT_W  = $clog2(NBYTES);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    SEND = 3'b010,
    DONE = 3'b100
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [NBYTES-1:0][7:0] cap;
  logic [CNT_W-1:0]       idx;
  logic                   in_idle;
  logic                   in_send;
  logic                   in_done;
  logic                   last_idx;
  logic                   xfer;

  // One-hot decode: each state is a single flop.
  assign in_idle  = state[0];
  assign in_send  = state[1];
  assign in_done  = state[2];
  assign last_idx = (idx == CNT_W'(NBYTES - 1));
  assign xfer     = in_send & out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (alu_done) state_nxt = SEND;
      SEND:    if (xfer && last_idx) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap <= '0;
      idx <= '0;
    end else if (in_idle && alu_done) begin
      cap <= {result_hi, result_lo};
      idx <= '0;
    end else if (xfer && !last_idx) begin
      idx <= idx + 1'b1;
    end
  end

  // A completion outside IDLE is dropped; set beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)                      overrun <= 1'b0;
    else if (alu_done && !in_idle)  overrun <= 1'b1;
    else if (clr_overrun)           overrun <= 1'b0;
  end

  assign out_valid = in_send;
  assign out_last  = in_send & last_idx;
  assign out_data  = in_send ? cap[idx] : 8'h00;
  assign busy      = in_send | in_done;
  assign sent      = in_done;

endmodule

// File: tb/tb_alu_result_reader.sv
// Randomized and directed bench for alu_result_reader with a queue-based
// scoreboard fed by a transaction-level reference model.
module tb_alu_result_reader;

  localparam int WIDTH = 16;
  localparam int NB    = 2 * WIDTH / 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             alu_done = 1'b0;
  logic [WIDTH-1:0] result_lo = '0;
  logic [WIDTH-1:0] result_hi = '0;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_last;
  logic             busy;
  logic             sent;
  logic             overrun;
  logic             clr_overrun = 1'b0;

  alu_result_reader #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .alu_done(alu_done),
    .result_lo(result_lo), .result_hi(result_hi),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .sent(sent),
    .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t exp_q[$];
  int   rem = 0;
  bit   done_f = 0, ovr_f = 0, rst_f = 0, started = 0;
  int   ncmp = 0, nbad = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    ncmp++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Reference model: a word occupies the block for its bytes plus one
  // completion cycle; completions arriving during that time are dropped.
  always @(posedge clk) begin
    logic [2*WIDTH-1:0] word;
    bit occupied;
    started = 1;
    if (reset) begin
      rem = 0; done_f = 0; ovr_f = 0; rst_f = 1;
      exp_q.delete();
    end else begin
      rst_f = 0;
      occupied = (rem > 0) || done_f;
      if (alu_done && occupied) ovr_f = 1;
      else if (clr_overrun)     ovr_f = 0;
      if (rem > 0) begin
        if (out_ready) begin
          rem--;
          done_f = (rem == 0);
        end
      end else if (done_f) begin
        done_f = 0;
      end else if (alu_done) begin
        word = {result_hi, result_lo};
        rem = NB;
        for (int i = 0; i < NB; i++) begin
          exp_t e;
          e.d = 8'((word >> (8 * i)) & 'hFF);
          e.l = (i == NB - 1);
          exp_q.push_back(e);
        end
      end
    end
  end

  // Monitor: compare outputs mid-cycle against the model and the queue.
  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", 32'(out_valid), 32'(rem > 0));
      chk("busy", 32'(busy), 32'((rem > 0) || done_f));
      chk("sent", 32'(sent), 32'(done_f));
      chk("overrun", 32'(overrun), 32'(ovr_f));
      if (rst_f) chk("out_data_reset", 32'(out_data), 32'h0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q[0].d));
          chk("out_last", 32'(out_last), 32'(exp_q[0].l));
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("out_last_idle", 32'(out_last), 32'h0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
  int waited;

  initial begin
    // Reset held across alu_done pulses
    reset = 1; result_lo = 16'hBEEF; result_hi = 16'h1234;
    cyc(1); alu_done = 1; cyc(1); alu_done = 0; cyc(1); alu_done = 1; cyc(1);
    alu_done = 0; reset = 0; cyc(1);

    // Straight stream with out_ready high
    out_ready = 1; alu_done = 1; cyc(1); alu_done = 0; cyc(8);

    // Backpressure pattern
    out_ready = 0; alu_done = 1; cyc(1); alu_done = 0;
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i][0]; cyc(1);
    end
    out_ready = 1; cyc(6);

    // Overrun during SEND, then clear
    alu_done = 1; cyc(1); result_lo = 16'h0001; cyc(1);
    alu_done = 0; result_lo = 16'hBEEF; cyc(8);
    clr_overrun = 1; cyc(1); clr_overrun = 0; cyc(2);

    // Reset after two bytes, then a fresh word
    alu_done = 1; cyc(1); alu_done = 0; cyc(2);
    reset = 1; cyc(1); reset = 0;
    result_lo = 16'h00A5; result_hi = 16'h5A00; alu_done = 1; cyc(1);
    alu_done = 0; cyc(7);

    // alu_done held continuously
    alu_done = 1; cyc(20); alu_done = 0; cyc(6);
    clr_overrun = 1; cyc(1); clr_overrun = 0;

    // Randomized traffic
    repeat (400) begin
      alu_done    = ($urandom % 4) == 0;
      result_lo   = 16'($urandom);
      result_hi   = 16'($urandom);
      out_ready   = ($urandom % 3) != 0;
      clr_overrun = ($urandom % 16) == 0;
      reset       = ($urandom % 80) == 0;
      cyc(1);
    end

    // Drain with a bounded wait
    reset = 0; alu_done = 0; clr_overrun = 0; out_ready = 1;
    waited = 0;
    while ((exp_q.size() != 0 || rem != 0 || done_f) && waited < 50) begin
      cyc(1); waited++;
    end
    chk("drain_queue", 32'(exp_q.size()), 32'h0);
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/alu_result_reader.md
Name: alu_result_reader

Overview:
Output-side counterpart of the ALU operand-loading path. It captures the two ALU result words (lo = product low / quotient, hi = product high / remainder) on the ALU completion pulse. It then streams them out byte by byte over a valid/ready handshake toward the host/test interface. The control FSM is one-hot, with an IDLE flop that resets to 1; all data and state storage is load-enabled flops.

Parameters:
WIDTH, 16, bit width of each result word; must be a multiple of 8 and at least 8
NBYTES, 2*WIDTH/8 (derived, localparam), bytes per transfer
CNT_W, clog2(NBYTES) (derived, localparam), byte-index counter width

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
alu_done  input  1  one-cycle pulse: result_lo/result_hi valid this cycle
result_lo  input  WIDTH  ALU low result word
result_hi  input  WIDTH  ALU high result word
out_data  output  8  current output byte
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts the byte when high together with out_valid
out_last  output  1  current byte is the final byte of the transfer
busy  output  1  high whenever the FSM is not in IDLE
sent  output  1  one-cycle pulse after the last byte is accepted
overrun  output  1  sticky flag: an alu_done arrived while the block was not IDLE
clr_overrun  input  1  clears overrun synchronously

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high, sampled only on the rising edge of clk, and has priority over every other input.
- Reset values: IDLE=1, SEND=0, DONE=0; out_valid=0, out_last=0, busy=0, sent=0, overrun=0, byte index=0, capture registers=0, out_data=0.
- One-hot states IDLE, SEND, DONE. Exactly one state flop is high at all times after reset.
- IDLE:
  - If alu_done=1 at an edge, load {result_hi, result_lo} into a 2*WIDTH capture register, clear the byte index, and go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - out_valid=1. out_data = capture[8*idx+7 : 8*idx]: byte 0 is result_lo[7:0], byte NBYTES-1 is result_hi[WIDTH-1:WIDTH-8].
  - out_last=1 when idx=NBYTES-1.
  - Handshake: a byte transfers at an edge where out_valid=1 and out_ready=1.
  - On a non-last transfer, idx increments.
  - On the last transfer, go to DONE.
  - While out_ready=0, out_data, out_last and idx hold stable. out_valid never drops before its byte transfers.
- DONE: lasts one cycle. sent=1 during this cycle, out_valid=0, then return to IDLE.
- Latency: alu_done at edge k gives out_valid=1 in the cycle after edge k. With out_ready tied high, the last byte transfers at edge k+NBYTES, sent is high during the following cycle, and IDLE is re-entered at edge k+NBYTES+1.
- Back-to-back transfers: alu_done is accepted in IDLE only. The earliest next capture is the edge at which IDLE is active, i.e. one cycle after the DONE cycle.
- Overrun:
  - alu_done=1 at an edge while in SEND or DONE sets overrun. The new data is dropped and the in-flight transfer continues unaffected.
  - clr_overrun=1 clears overrun. If clr_overrun and an overrun event coincide at the same edge, set wins.
- Outputs are registered or decoded from state flops only. There is no combinational path from out_ready to out_valid.
- Reset mid-transfer: returns the block to the reset values at the next edge. The partially sent word is discarded and no sent pulse is produced.
- busy = SEND | DONE.

Test Plan:
- Reset, then hold reset=1 over 3 edges while alu_done pulses -> IDLE=1, out_valid=0, busy=0, overrun=0 throughout; no capture.
- alu_done with result_lo=16'hBEEF, result_hi=16'h1234, out_ready=1 -> out_data sequence EF, BE, 34, 12 on consecutive cycles; out_last only on 12; sent pulses 1 cycle later; busy deasserts after sent.
- Same data with out_ready toggling 1,0,0,1,0,1,1 -> out_data/out_last stable while out_ready=0; exactly 4 transfers in order EF, BE, 34, 12; out_valid never drops mid-transfer.
- Second alu_done (lo=16'h0001) during SEND of the first word -> overrun=1 and stays 1; output stream is still EF, BE, 34, 12; clr_overrun pulse -> overrun=0 next cycle.
- Reset asserted after 2 bytes transferred -> next cycle out_valid=0, IDLE=1, no sent; new alu_done with lo=16'h00A5, hi=16'h5A00 -> A5, 00, 00, 5A.
- Back-to-back: alu_done held every cycle with out_ready=1 -> captures only in IDLE cycles, one transfer per NBYTES+2 cycles; overrun set by the alu_done pulses that arrive during SEND/DONE.
